mac_arbiter: RTL and testbench

MAC_ARBITER -- requirements
Module: mac_arbiter

---
 rtl/mac_arbiter_if.sv | 60 ++++++
 rtl/mac_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mac_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mac_arbiter_if
//  Brief    : Bundle of request, shared-pipeline and result signals between
//             the two-requester MAC arbiter and its environment.
//  Revision : 1.0 - initial release
// ============================================================================
interface mac_arbiter_if #(
    parameter int size          = 8,
    parameter int DATA_OUT_size = 16
);
    logic                     en;

    logic                     req0_valid;
    logic [size-1:0]          req0_a;
    logic [size-1:0]          req0_b;
    logic [size-1:0]          req0_c;
    logic                     req0_ready;

    logic                     req1_valid;
    logic [size-1:0]          req1_a;
    logic [size-1:0]          req1_b;
    logic [size-1:0]          req1_c;
    logic                     req1_ready;

    logic [size-1:0]          mac_a;
    logic [size-1:0]          mac_b;
    logic [size-1:0]          mac_c;
    logic [DATA_OUT_size-1:0] mac_out;

    logic                     res_valid;
    logic                     res_id;
    logic [DATA_OUT_size-1:0] res_data;
    logic                     busy;

    // Environment side: requesters, shared pipeline and result consumer.
    modport master (
        output en,
        output req0_valid, req0_a, req0_b, req0_c,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_c,
        input  req1_ready,
        input  mac_a, mac_b, mac_c,
        output mac_out,
        input  res_valid, res_id, res_data, busy
    );

    // Arbiter side.
    modport slave (
        input  en,
        input  req0_valid, req0_a, req0_b, req0_c,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_c,
        output req1_ready,
        output mac_a, mac_b, mac_c,
        input  mac_out,
        output res_valid, res_id, res_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/mac_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mac_arbiter
//  Brief    : Round-robin scheduler sharing one A*B+C pipeline between two
//             requesters. A {valid,id} tag travels alongside each issue so
//             the result leaving the pipeline is labelled with its owner.
//             Optional feature macro: MAC_ARB_CNT_EN adds per-requester
//             16-bit transfer counters cnt0/cnt1.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_arbiter #(
    parameter int size          = 8,
    parameter int DATA_OUT_size = 16,
    parameter int LATENCY       = 3     // must be >= 1
) (
    input  wire logic         clock,
    input  wire logic         reset,
    mac_arbiter_if.slave      bus
`ifdef MAC_ARB_CNT_EN
    ,
    output logic [15:0]       cnt0,
    output logic [15:0]       cnt1
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t                   state_q;
    state_t                   state_d;

    // Requester granted by the most recent transfer.
    logic                     last_grant_q;

    logic [LATENCY-1:0]       tag_valid_q;
    logic [LATENCY-1:0]       tag_id_q;

    logic                     grant0;
    logic                     grant1;
    logic                     transfer;
    logic                     tags_pending;
    logic [size-1:0]          op_a;
    logic [size-1:0]          op_b;
    logic [size-1:0]          op_c;
    logic [DATA_OUT_size-1:0] result;

    assign transfer     = (grant0 & bus.req0_valid) | (grant1 & bus.req1_valid);
    assign tags_pending = |tag_valid_q;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: DRAIN only returns to IDLE once every tag has left.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.en) state_d = S_ACTIVE;
            S_ACTIVE: if (!bus.en) state_d = S_DRAIN;
            S_DRAIN: begin
                if (bus.en) begin
                    state_d = S_ACTIVE;
                end else if (!tags_pending) begin
                    state_d = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Round-robin grant, only while ACTIVE; contention goes to the requester
    // that did not win the previous transfer.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == S_ACTIVE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (last_grant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else if (bus.req0_valid) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    // Operand mux towards the shared pipeline; zero when nothing is issued.
    always_comb begin
        op_a = '0;
        op_b = '0;
        op_c = '0;
        if (grant0) begin
            op_a = bus.req0_a;
            op_b = bus.req0_b;
            op_c = bus.req0_c;
        end else if (grant1) begin
            op_a = bus.req1_a;
            op_b = bus.req1_b;
            op_c = bus.req1_c;
        end
    end

    // Remember the last winner. Reset to requester 1 so requester 0 takes
    // the first contention.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (transfer) begin
            last_grant_q <= grant1;
        end
    end

    // Tag shift register mirroring the pipeline depth; advances every clock
    // since results are never back-pressured.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid_q <= '0;
            tag_id_q    <= '0;
        end else begin
            tag_valid_q[0] <= transfer;
            tag_id_q[0]    <= grant1;
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_id_q[i]    <= tag_id_q[i-1];
            end
        end
    end

`ifdef MAC_ARB_CNT_EN
    // Per-requester transfer counters, wrapping naturally at 16 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt0 <= 16'd0;
            cnt1 <= 16'd0;
        end else begin
            if (grant0 && bus.req0_valid) cnt0 <= cnt0 + 16'd1;
            if (grant1 && bus.req1_valid) cnt1 <= cnt1 + 16'd1;
        end
    end
`else
    // Transfer counters are not built in this configuration.
`endif

    assign result         = bus.mac_out;

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.mac_a      = op_a;
    assign bus.mac_b      = op_b;
    assign bus.mac_c      = op_c;
    assign bus.res_valid  = tag_valid_q[LATENCY-1];
    assign bus.res_id     = tag_id_q[LATENCY-1];
    assign bus.res_data   = result;
    assign bus.busy       = (state_q != S_IDLE) | tags_pending;

endmodule
`default_nettype wire

// File: tb/tb_mac_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_arbiter
//  Brief    : Directed self-checking bench for mac_arbiter with a 3-stage
//             A*B+C pipeline model attached to the shared-pipeline ports.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_arbiter;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    mac_arbiter_if #(.size(8), .DATA_OUT_size(16)) bus ();

`ifdef MAC_ARB_CNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    mac_arbiter #(.size(8), .DATA_OUT_size(16), .LATENCY(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef MAC_ARB_CNT_EN
        ,
        .cnt0  (cnt0),
        .cnt1  (cnt1)
`endif
    );

    // Clock generation, 10 ns period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Shared pipeline model: three register stages of A*B+C.
    logic [15:0] pipe [3];
    always @(posedge clock) begin
        pipe[0] <= ({8'd0, bus.mac_a} * {8'd0, bus.mac_b}) + {8'd0, bus.mac_c};
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign bus.mac_out = pipe[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bus.req0_valid = v;
        bus.req0_a     = a;
        bus.req0_b     = b;
        bus.req0_c     = c;
    endtask

    task automatic drive1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bus.req1_valid = v;
        bus.req1_a     = a;
        bus.req1_b     = b;
        bus.req1_c     = c;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.en   = 1'b0;
        drive0(1'b0, 8'd0, 8'd0, 8'd0);
        drive1(1'b0, 8'd0, 8'd0, 8'd0);

        // ---- Reset state ----
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_ready0", 32'(bus.req0_ready), 32'd0);
        check("rst_ready1", 32'(bus.req1_ready), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_id", 32'(bus.res_id), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        // ---- Single issue from requester 0: 3*4+5 = 17 after 3 cycles ----
        bus.en = 1'b1;
        #1;
        check("idle_no_grant", 32'(bus.req0_ready), 32'd0);
        tick();                                   // now ACTIVE
        drive0(1'b1, 8'd3, 8'd4, 8'd5);
        #1;
        check("single_ready0", 32'(bus.req0_ready), 32'd1);
        check("single_ready1", 32'(bus.req1_ready), 32'd0);
        check("single_mac_a", 32'(bus.mac_a), 32'd3);
        check("single_mac_c", 32'(bus.mac_c), 32'd5);
        tick();                                   // k+1
        drive0(1'b0, 8'd0, 8'd0, 8'd0);
        #1;
        check("single_busy", 32'(bus.busy), 32'd1);
        check("single_mac_a_idle", 32'(bus.mac_a), 32'd0);
        tick();                                   // k+2
        check("single_early", 32'(bus.res_valid), 32'd0);
        tick();                                   // k+3
        check("single_res_valid", 32'(bus.res_valid), 32'd1);
        check("single_res_id", 32'(bus.res_id), 32'd0);
        check("single_res_data", 32'(bus.res_data), 32'd17);

        // ---- Operand extremes via requester 1: 255*255+255 = 65280 ----
        drive1(1'b1, 8'd255, 8'd255, 8'd255);
        #1;
        check("max_ready1", 32'(bus.req1_ready), 32'd1);
        check("max_ready0", 32'(bus.req0_ready), 32'd0);
        tick();
        drive1(1'b0, 8'd0, 8'd0, 8'd0);
        tick();
        tick();
        check("max_res_valid", 32'(bus.res_valid), 32'd1);
        check("max_res_id", 32'(bus.res_id), 32'd1);
        check("max_res_data", 32'(bus.res_data), 32'd65280);

        // ---- Contention for 6 cycles: grants 0,1,0,1,0,1 ----
        // req0 issue j computes (j+1)*2+3; req1 always 4*5+6 = 26.
        for (int i = 0; i < 9; i++) begin
            if (i < 6) begin
                drive0(1'b1, 8'(i + 1), 8'd2, 8'd3);
                drive1(1'b1, 8'd4, 8'd5, 8'd6);
            end else begin
                drive0(1'b0, 8'd0, 8'd0, 8'd0);
                drive1(1'b0, 8'd0, 8'd0, 8'd0);
            end
            #1;
            if (i < 6) begin
                check($sformatf("rr_ready0_%0d", i), 32'(bus.req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
                check($sformatf("rr_ready1_%0d", i), 32'(bus.req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            end
            if (i >= 3) begin
                check($sformatf("rr_res_valid_%0d", i - 3), 32'(bus.res_valid), 32'd1);
                check($sformatf("rr_res_id_%0d", i - 3), 32'(bus.res_id), 32'((i - 3) % 2));
                check($sformatf("rr_res_data_%0d", i - 3), 32'(bus.res_data),
                      ((i - 3) % 2 == 1) ? 32'd26 : 32'((i - 3 + 1) * 2 + 3));
            end
            tick();
        end

        // ---- Two issues then en=0: drain without further grants ----
        drive0(1'b1, 8'd2, 8'd2, 8'd0);           // k: 4
        #1;
        check("drain_issue0", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.en = 1'b0;                            // k+1: still ACTIVE
        drive0(1'b0, 8'd2, 8'd2, 8'd0);
        drive1(1'b1, 8'd3, 8'd3, 8'd1);           // 10
        #1;
        check("drain_issue1", 32'(bus.req1_ready), 32'd1);
        tick();
        drive0(1'b1, 8'd2, 8'd2, 8'd0);           // k+2: DRAIN
        #1;
        check("drain_no_ready0", 32'(bus.req0_ready), 32'd0);
        check("drain_no_ready1", 32'(bus.req1_ready), 32'd0);
        check("drain_busy", 32'(bus.busy), 32'd1);
        tick();                                   // k+3
        check("drain_res0_valid", 32'(bus.res_valid), 32'd1);
        check("drain_res0_id", 32'(bus.res_id), 32'd0);
        check("drain_res0_data", 32'(bus.res_data), 32'd4);
        tick();                                   // k+4
        check("drain_res1_valid", 32'(bus.res_valid), 32'd1);
        check("drain_res1_id", 32'(bus.res_id), 32'd1);
        check("drain_res1_data", 32'(bus.res_data), 32'd10);
        tick();                                   // k+5: tags clear, still DRAIN
        check("drain_tail_valid", 32'(bus.res_valid), 32'd0);
        check("drain_tail_busy", 32'(bus.busy), 32'd1);
        tick();                                   // k+6: IDLE
        check("drain_idle_busy", 32'(bus.busy), 32'd0);
        check("drain_idle_ready0", 32'(bus.req0_ready), 32'd0);
        drive0(1'b0, 8'd0, 8'd0, 8'd0);
        drive1(1'b0, 8'd0, 8'd0, 8'd0);

        // ---- Reset with two results in flight ----
        bus.en = 1'b1;
        tick();                                   // ACTIVE
        drive1(1'b1, 8'd1, 8'd1, 8'd1);
        #1;
        check("rstflight_issue1", 32'(bus.req1_ready), 32'd1);
        tick();
        drive1(1'b0, 8'd0, 8'd0, 8'd0);
        drive0(1'b1, 8'd1, 8'd1, 8'd1);           // last winner becomes req0
        #1;
        check("rstflight_issue0", 32'(bus.req0_ready), 32'd1);
        tick();
        drive0(1'b0, 8'd0, 8'd0, 8'd0);
        bus.en = 1'b0;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        check("rstflight_valid_a", 32'(bus.res_valid), 32'd0);
        check("rstflight_busy", 32'(bus.busy), 32'd0);
        tick();
        check("rstflight_valid_b", 32'(bus.res_valid), 32'd0);
        bus.en = 1'b1;
        tick();                                   // ACTIVE again
        check("rstflight_valid_c", 32'(bus.res_valid), 32'd0);
        drive0(1'b1, 8'd1, 8'd1, 8'd1);
        drive1(1'b1, 8'd1, 8'd1, 8'd1);
        #1;
        check("rstflight_first_ready0", 32'(bus.req0_ready), 32'd1);
        check("rstflight_first_ready1", 32'(bus.req1_ready), 32'd0);
        drive0(1'b0, 8'd0, 8'd0, 8'd0);
        drive1(1'b0, 8'd0, 8'd0, 8'd0);

`ifdef MAC_ARB_CNT_EN
        // ---- Counter wrap: 65536 requester-1 transfers ----
        bus.en = 1'b0;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        check("cnt1_reset", 32'(cnt1), 32'd0);
        bus.en = 1'b1;
        tick();
        drive1(1'b1, 8'd1, 8'd1, 8'd1);
        repeat (65535) tick();
        check("cnt1_max", 32'(cnt1), 32'd65535);
        tick();
        drive1(1'b0, 8'd0, 8'd0, 8'd0);
        #1;
        check("cnt1_wrap", 32'(cnt1), 32'd0);
        check("cnt0_idle", 32'(cnt0), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
